// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two masters (m0 = fetch,
// m1 = load/store). One grant per cycle, round-robin between simultaneous
// requesters, response returned on the winner's port one cycle later.
// Accesses outside [RAM_BASE, RAM_BASE+RAM_SIZE) never reach the RAM and
// complete with an error flag.
module ram_arbiter #(
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter logic [31:0] RAM_SIZE = 32'h0010_0000,
  parameter int          AW       = $clog2(RAM_SIZE) - 2
) (
  input  logic          clk,
  input  logic          rst,
  // master 0 (instruction fetch)
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  // master 1 (data load/store)
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  // RAM side
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_wstrb,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic {
    MST0 = 1'b0,
    MST1 = 1'b1
  } mst_e;

  // Round-robin pointer: the master that wins when both request.
  mst_e        r_prio;

  // Response stage, one entry, loaded on every grant.
  logic        r_rsp_valid;
  mst_e        r_rsp_id;
  logic        r_rsp_read;
  logic        r_rsp_err;

  logic        w_gnt;
  mst_e        w_win;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_offset;
  logic        w_in_range;
  logic        w_rsp_live;
  logic [31:0] w_rsp_data;

  // Arbitration: pick a winner (nothing while in reset) and mux its request.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_gnt = 1'b0;
    w_win = MST0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        w_gnt = 1'b1;
        w_win = r_prio;
      end else if (m0_req) begin
        w_gnt = 1'b1;
        w_win = MST0;
      end else if (m1_req) begin
        w_gnt = 1'b1;
        w_win = MST1;
      end
    end

    w_we    = (w_win == MST1) ? m1_we    : m0_we;
    w_addr  = (w_win == MST1) ? m1_addr  : m0_addr;
    w_wdata = (w_win == MST1) ? m1_wdata : m0_wdata;
    w_wstrb = (w_win == MST1) ? m1_wstrb : m0_wstrb;

    // Unsigned wrap makes addresses below the base land far out of range.
    w_offset   = w_addr - RAM_BASE;
    w_in_range = (w_offset < RAM_SIZE);
  end

  assign m0_gnt = w_gnt && (w_win == MST0);
  assign m1_gnt = w_gnt && (w_win == MST1);

  // Out-of-range grants are answered locally and never touch the RAM.
  assign ram_en    = w_gnt && w_in_range;
  assign ram_we    = ram_en && w_we;
  assign ram_addr  = w_offset[AW+1:2];
  assign ram_wdata = w_wdata;
  assign ram_wstrb = ram_we ? w_wstrb : 4'b0000;

  // Priority pointer and response-stage registers.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values and updates together.
    if (rst) begin
      r_prio      <= MST0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= MST0;
      r_rsp_read  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_gnt;
      if (w_gnt) begin
        r_prio     <= (w_win == MST0) ? MST1 : MST0;
        r_rsp_id   <= w_win;
        r_rsp_read <= !w_we;
        r_rsp_err  <= !w_in_range;
      end
    end
  end

  // A response pending across the reset edge is dropped: reset forces the
  // outputs quiet in the same cycle.
  assign w_rsp_live = r_rsp_valid && !rst;
  assign w_rsp_data = (r_rsp_read && !r_rsp_err) ? ram_rdata : 32'h0;

  assign m0_rvalid = w_rsp_live && (r_rsp_id == MST0);
  assign m1_rvalid = w_rsp_live && (r_rsp_id == MST1);
  assign m0_rdata  = m0_rvalid ? w_rsp_data : 32'h0;
  assign m1_rdata  = m1_rvalid ? w_rsp_data : 32'h0;
  assign m0_err    = m0_rvalid && r_rsp_err;
  assign m1_err    = m1_rvalid && r_rsp_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model (grant choice, shadow memory,
// expected response) held in this module.
module tb_ram_arbiter;

  localparam logic [31:0] TB_BASE = 32'h0000_0000;
  localparam logic [31:0] TB_SIZE = 32'h0010_0000;
  localparam int          AW      = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_wstrb;

  // Second instance with a high base, sharing the master inputs.
  logic        hi_m0_gnt, hi_m0_rvalid, hi_m0_err, hi_m1_gnt, hi_m1_rvalid, hi_m1_err;
  logic [31:0] hi_m0_rdata, hi_m1_rdata;
  logic        hi_ram_en, hi_ram_we;
  logic [AW-1:0] hi_ram_addr;
  logic [31:0] hi_ram_wdata;
  logic [3:0]  hi_ram_wstrb;
  logic [31:0] hi_ram_rdata = 32'hA5A5_A5A5;

  ram_arbiter u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
  );

  ram_arbiter #(.RAM_BASE(32'h8000_0000)) u_dut_hi (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_gnt(hi_m0_gnt), .m0_rvalid(hi_m0_rvalid),
    .m0_rdata(hi_m0_rdata), .m0_err(hi_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_gnt(hi_m1_gnt), .m1_rvalid(hi_m1_rvalid),
    .m1_rdata(hi_m1_rdata), .m1_err(hi_m1_err),
    .ram_en(hi_ram_en), .ram_we(hi_ram_we), .ram_addr(hi_ram_addr),
    .ram_wdata(hi_ram_wdata), .ram_wstrb(hi_ram_wstrb), .ram_rdata(hi_ram_rdata)
  );

  // RAM behind the main instance (first 256 words); read data is random
  // junk whenever no read was issued.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    ram_rdata <= $urandom;
    if (ram_en && ram_addr < AW'(256)) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[7:0]];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:255];
  logic        m_prio;
  logic        pend_valid, pend_id, pend_err;
  logic [31:0] pend_rdata;
  logic        mg0, mg1;
  logic        last_g0, last_g1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs must already be driven. Checks the response due
  // now, then the grant/RAM request, then advances the model and the clock.
  task automatic step();
    logic        exp_rv0, exp_rv1, g, win, inr, we;
    logic [31:0] a, wd, off;
    logic [3:0]  ws;
    logic [7:0]  idx;
    #1;
    exp_rv0 = !rst && pend_valid && !pend_id;
    exp_rv1 = !rst && pend_valid &&  pend_id;
    check("m0_rvalid", m0_rvalid, exp_rv0);
    check("m1_rvalid", m1_rvalid, exp_rv1);
    if (exp_rv0) begin
      check("m0_rdata", m0_rdata, pend_rdata);
      check("m0_err", m0_err, pend_err);
    end
    if (exp_rv1) begin
      check("m1_rdata", m1_rdata, pend_rdata);
      check("m1_err", m1_err, pend_err);
    end
    if (rst) begin
      check("rst_m0_rdata", m0_rdata, 0);
      check("rst_m1_rdata", m1_rdata, 0);
      check("rst_m0_err", m0_err, 0);
      check("rst_m1_err", m1_err, 0);
      check("rst_ram_we", ram_we, 0);
    end

    g   = !rst && (m0_req || m1_req);
    win = (m0_req && m1_req) ? m_prio : m1_req;
    last_g0 = m0_gnt;
    last_g1 = m1_gnt;
    check("m0_gnt", m0_gnt, g && !win);
    check("m1_gnt", m1_gnt, g && win);

    a   = win ? m1_addr  : m0_addr;
    we  = win ? m1_we    : m0_we;
    wd  = win ? m1_wdata : m0_wdata;
    ws  = win ? m1_wstrb : m0_wstrb;
    off = a - TB_BASE;
    inr = off < TB_SIZE;
    idx = off[9:2];
    check("ram_en", ram_en, g && inr);
    if (g && inr) begin
      check("ram_we", ram_we, we);
      check("ram_addr", 32'(ram_addr), 32'(off[AW+1:2]));
      check("ram_wstrb", ram_wstrb, we ? ws : 4'b0000);
      if (we) begin
        check("ram_wdata", ram_wdata, wd);
        for (int b = 0; b < 4; b++)
          if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end

    pend_valid = g;
    if (g) begin
      pend_id    = win;
      pend_err   = !inr;
      pend_rdata = (!we && inr) ? ref_mem[idx] : 32'h0;
      m_prio     = !win;
    end
    if (rst) m_prio = 1'b0;
    mg0 = g && !win;
    mg1 = g && win;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic set_m0(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; m0_wstrb = s;
  endtask

  task automatic set_m1(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; m1_wstrb = s;
  endtask

  initial begin
    logic [31:0] oor_addr [2];
    oor_addr[0] = 32'h7FFF_FFFC;
    oor_addr[1] = 32'h8010_0000;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    m_prio = 1'b0; pend_valid = 1'b0; pend_id = 1'b0; pend_err = 1'b0;
    pend_rdata = 32'h0; mg0 = 1'b0; mg1 = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;

    // Reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Read then write, m0 only.
    set_m0(1'b0, 32'h10, 32'h0, 4'hF);
    step();
    idle();
    step();
    set_m0(1'b1, 32'h10, 32'h1234_5678, 4'b0011);
    step();
    idle();
    step();
    set_m0(1'b0, 32'h12, 32'h0, 4'h0);   // low bits ignored; sees merged word
    step();
    idle();
    step();

    // Contention from reset: grants alternate starting with m0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_m0(1'b0, 32'(4 * i), 32'h0, 4'h0);
      set_m1(1'b0, 32'(4 * i + 64), 32'h0, 4'h0);
      step();
      check("cont_g0", last_g0, (i % 2) == 0);
      check("cont_g1", last_g1, (i % 2) == 1);
    end
    idle();
    step();

    // Out-of-range reads on the high-base instance.
    for (int k = 0; k < 2; k++) begin
      set_m1(1'b0, oor_addr[k], 32'h0, 4'h0);
      #1;
      check("hi_m1_gnt", hi_m1_gnt, 1);
      check("hi_ram_en", hi_ram_en, 0);
      step();
      idle();
      #1;
      check("hi_m1_rvalid", hi_m1_rvalid, 1);
      check("hi_m1_err", hi_m1_err, 1);
      check("hi_m1_rdata", hi_m1_rdata, 0);
      check("hi_m0_rvalid", hi_m0_rvalid, 0);
      step();
    end
    // In-range on the high base reaches its RAM at word 4.
    set_m1(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    #1;
    check("hi_in_ram_en", hi_ram_en, 1);
    check("hi_in_ram_addr", 32'(hi_ram_addr), 4);
    step();
    idle();
    #1;
    check("hi_in_rdata", hi_m1_rdata, 32'hA5A5_A5A5);
    check("hi_in_err", hi_m1_err, 0);
    step();
    // Main instance: one word past the end and a wrapped address.
    set_m0(1'b0, 32'h0010_0000, 32'h0, 4'h0);
    step();
    set_m0(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF);
    step();
    idle();
    step();

    // Priority memory: m1 alone, two idle cycles, then both -> m0.
    set_m1(1'b0, 32'h20, 32'h0, 4'h0);
    step();
    idle();
    step();
    step();
    set_m0(1'b0, 32'h24, 32'h0, 4'h0);
    set_m1(1'b0, 32'h28, 32'h0, 4'h0);
    step();
    check("prio_mem_g0", last_g0, 1);
    m0_req = 1'b0;
    step();
    idle();
    step();

    // Reset mid-operation.
    set_m0(1'b0, 32'h30, 32'h0, 4'h0);
    step();
    m0_req = 1'b0;
    set_m1(1'b0, 32'h34, 32'h0, 4'h0);
    rst = 1'b1;
    step();
    check("rst_mid_g1", last_g1, 0);
    rst = 1'b0;
    set_m0(1'b0, 32'h38, 32'h0, 4'h0);
    step();
    check("post_rst_g0", last_g0, 1);
    m0_req = 1'b0;
    step();
    idle();
    step();

    // Back-to-back reads on m1.
    for (int i = 0; i < 4; i++) begin
      set_m1(1'b0, 32'(4 * i), 32'h0, 4'h0);
      step();
    end
    idle();
    step();

    // Random traffic, requests held until granted.
    for (int c = 0; c < 800; c++) begin
      if (!m0_req || mg0) begin
        if ($urandom_range(0, 3) != 0)
          set_m0(1'($urandom),
                 ($urandom_range(0, 7) == 0) ? (32'h0010_0000 | ($urandom & 32'h07FF_FFFF))
                                             : ($urandom & 32'h3FF),
                 $urandom, 4'($urandom));
        else
          m0_req = 1'b0;
      end
      if (!m1_req || mg1) begin
        if ($urandom_range(0, 3) != 0)
          set_m1(1'($urandom),
                 ($urandom_range(0, 7) == 0) ? (32'hFFF0_0000 | $urandom)
                                             : ($urandom & 32'h3FF),
                 $urandom, 4'($urandom));
        else
          m1_req = 1'b0;
      end
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
